// File: rtl/sd_cmd_sequencer.sv
// SD SPI-mode command sequencer: sends CMD/ARG/CRC through spi_front, polls for R1, owns cs_n.
// Optional SD_CRC7_EN computes a real CRC7; otherwise fixed CRC bytes for CMD0/CMD8 are used.
module sd_cmd_sequencer #(
  parameter int unsigned POLL_MAX = 8
) (
  input  logic        spi_clk_in,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_keep_cs,
  input  logic        cs_release,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_timeout,
  output logic [7:0]  r1,
  output logic        cs_n,
  output logic        spi_begin,
  output logic        spi_wide,
  output logic [31:0] data_mosi,
  input  logic        spi_busy,
  input  logic [31:0] data_miso
);

  typedef enum logic [2:0] {StIdle, StCmd, StArg, StCrc, StPoll, StDone} state_e;

  localparam logic [7:0] PollMax = 8'(POLL_MAX);

  state_e      state_q, state_d;
  logic        wait_q, wait_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic        keep_q, keep_d;
  logic        cs_n_q, cs_n_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  r1_q, r1_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [7:0]  poll_cnt_inc;
  logic [7:0]  crc_byte;
  logic        xfer_done;

`ifdef SD_CRC7_EN
  logic [6:0] crc_q, crc_d;

  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign crc_byte = {crc_q, 1'b1};
`else
  always_comb begin
    case (index_q)
      6'd0:    crc_byte = 8'h95;
      6'd8:    crc_byte = 8'h87;
      default: crc_byte = 8'h01;
    endcase
  end
`endif

  assign poll_cnt_inc = poll_cnt_q + 8'd1;
  assign cmd_busy     = (state_q != StIdle);
  assign cmd_done     = (state_q == StDone);
  assign cmd_timeout  = timeout_q;
  assign r1           = r1_q;
  assign cs_n         = cs_n_q;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    index_d    = index_q;
    arg_d      = arg_q;
    keep_d     = keep_q;
    cs_n_d     = cs_n_q;
    timeout_d  = timeout_q;
    r1_d       = r1_q;
    poll_cnt_d = poll_cnt_q;
`ifdef SD_CRC7_EN
    crc_d      = crc_q;
`endif
    spi_begin  = 1'b0;
    spi_wide   = 1'b0;
    data_mosi  = '0;
    xfer_done  = 1'b0;

    case (state_q)
      StCmd:   data_mosi = {24'h0, 2'b01, index_q};
      StArg:   begin
        data_mosi = arg_q;
        spi_wide  = 1'b1;
      end
      StCrc:   data_mosi = {24'h0, crc_byte};
      StPoll:  data_mosi = 32'hFFFF_FFFF;
      default: data_mosi = '0;
    endcase

    // Shared ISSUE/WAIT handshake for every transfer state.
    if (state_q inside {StCmd, StArg, StCrc, StPoll}) begin
      if (!wait_q) begin
        spi_begin = 1'b1;
        if (spi_busy) wait_d = 1'b1;
      end else if (!spi_busy) begin
        wait_d    = 1'b0;
        xfer_done = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (cmd_start) begin
          index_d    = cmd_index;
          arg_d      = cmd_arg;
          keep_d     = cmd_keep_cs;
          timeout_d  = 1'b0;
          cs_n_d     = 1'b0;
          poll_cnt_d = '0;
          wait_d     = 1'b0;
`ifdef SD_CRC7_EN
          crc_d      = crc7({2'b01, cmd_index, cmd_arg});
`endif
          state_d    = StCmd;
        end else if (cs_release) begin
          cs_n_d = 1'b1;
        end
      end
      StCmd:  if (xfer_done) state_d = StArg;
      StArg:  if (xfer_done) state_d = StCrc;
      StCrc:  if (xfer_done) state_d = StPoll;
      StPoll: begin
        if (xfer_done) begin
          if (!data_miso[7]) begin
            r1_d    = data_miso[7:0];
            state_d = StDone;
          end else if (poll_cnt_inc == PollMax) begin
            r1_d      = 8'hFF;
            timeout_d = 1'b1;
            state_d   = StDone;
          end else begin
            poll_cnt_d = poll_cnt_inc;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!keep_q || timeout_q) cs_n_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge spi_clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_q     <= 1'b0;
      index_q    <= '0;
      arg_q      <= '0;
      keep_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      timeout_q  <= 1'b0;
      r1_q       <= 8'hFF;
      poll_cnt_q <= '0;
`ifdef SD_CRC7_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
      keep_q     <= keep_d;
      cs_n_q     <= cs_n_d;
      timeout_q  <= timeout_d;
      r1_q       <= r1_d;
      poll_cnt_q <= poll_cnt_d;
`ifdef SD_CRC7_EN
      crc_q      <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: behavioural spi_front plus a card that answers polls with
// a run of fill bytes followed by one response byte.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start, cmd_keep_cs, cs_release;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_busy, cmd_done, cmd_timeout, cs_n, spi_begin, spi_wide;
  logic [7:0]  r1;
  logic [31:0] data_mosi, data_miso;
  logic        spi_busy;

  int total = 0;
  int bad   = 0;

  sd_cmd_sequencer #(.POLL_MAX(8)) dut (
    .spi_clk_in (clk),
    .rst        (rst),
    .cmd_start  (cmd_start),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .cmd_keep_cs(cmd_keep_cs),
    .cs_release (cs_release),
    .cmd_busy   (cmd_busy),
    .cmd_done   (cmd_done),
    .cmd_timeout(cmd_timeout),
    .r1         (r1),
    .cs_n       (cs_n),
    .spi_begin  (spi_begin),
    .spi_wide   (spi_wide),
    .data_mosi  (data_mosi),
    .spi_busy   (spi_busy),
    .data_miso  (data_miso)
  );

  always #5 clk = ~clk;

  // Card behaviour, set by the stimulus before each command.
  int         card_nff;
  logic [7:0] card_fill, card_resp;

  // spi_front model: each transfer keeps busy high for 3 cycles and logs the MOSI bytes.
  logic [7:0] log_mem [64];
  int         log_n;
  int         polls;
  int         m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_busy  <= 1'b0;
      m_cnt     <= 0;
      log_n     <= 0;
      polls     <= 0;
      data_miso <= 32'hFFFF_FFFF;
    end else if (cmd_start && !cmd_busy) begin
      log_n <= 0;
      polls <= 0;
    end else if (!spi_busy && spi_begin) begin
      spi_busy <= 1'b1;
      m_cnt    <= 2;
      if (log_n < 56) begin
        if (spi_wide) begin
          log_mem[log_n]   <= data_mosi[31:24];
          log_mem[log_n+1] <= data_mosi[23:16];
          log_mem[log_n+2] <= data_mosi[15:8];
          log_mem[log_n+3] <= data_mosi[7:0];
          log_n            <= log_n + 4;
        end else begin
          log_mem[log_n] <= data_mosi[7:0];
          log_n          <= log_n + 1;
        end
      end
      if (!spi_wide && data_mosi == 32'hFFFF_FFFF) begin
        polls     <= polls + 1;
        data_miso <= {24'hFF_FFFF, (polls < card_nff) ? card_fill : card_resp};
      end
    end else if (spi_busy) begin
      if (m_cnt == 0) spi_busy <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        keep;
    int          nff;
    logic [7:0]  fill;
    logic [7:0]  resp;
    logic [7:0]  crc;
    logic [7:0]  r1;
    logic        to;
    int          polls;
    logic        cs;
  } vec_t;

  vec_t vecs [7];

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic keep);
    @(negedge clk);
    cmd_index   = idx;
    cmd_arg     = arg;
    cmd_keep_cs = keep;
    cmd_start   = 1'b1;
    @(negedge clk);
    cmd_start   = 1'b0;
    chk("busy_after_accept", {31'd0, cmd_busy}, 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [7:0] e [6];
    card_nff  = v.nff;
    card_fill = v.fill;
    card_resp = v.resp;
    start_cmd(v.idx, v.arg, v.keep);
    wait_done();
    chk($sformatf("v%0d_r1", n), {24'd0, r1}, {24'd0, v.r1});
    chk($sformatf("v%0d_timeout", n), {31'd0, cmd_timeout}, {31'd0, v.to});
    chk($sformatf("v%0d_nbytes", n), log_n, 6 + v.polls);
    e[0] = {2'b01, v.idx};
    e[1] = v.arg[31:24];
    e[2] = v.arg[23:16];
    e[3] = v.arg[15:8];
    e[4] = v.arg[7:0];
    e[5] = v.crc;
    for (int i = 0; i < log_n && i < 40; i++)
      chk($sformatf("v%0d_mosi%0d", n, i), {24'd0, log_mem[i]},
          {24'd0, (i < 6) ? e[i] : 8'hFF});
    @(negedge clk);
    chk($sformatf("v%0d_cs_after", n), {31'd0, cs_n}, {31'd0, v.cs});
    chk($sformatf("v%0d_idle_busy", n), {30'd0, cmd_busy, cmd_done}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_cs_hold", n), {31'd0, cs_n}, {31'd0, v.cs});
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    chk($sformatf("v%0d_cs_release", n), {31'd0, cs_n}, 32'd1);
    chk($sformatf("v%0d_r1_hold", n), {24'd0, r1}, {24'd0, v.r1});
  endtask

  initial begin
`ifdef SD_CRC7_EN
    vecs[0] = '{6'd0,  32'h0,        1'b0, 2,  8'hFF, 8'h01, 8'h95, 8'h01, 1'b0, 3, 1'b1};
    vecs[1] = '{6'd8,  32'h1AA,      1'b0, 0,  8'hFF, 8'h01, 8'h87, 8'h01, 1'b0, 1, 1'b1};
    vecs[2] = '{6'd17, 32'h0,        1'b1, 1,  8'hFF, 8'h00, 8'h55, 8'h00, 1'b0, 2, 1'b0};
    vecs[3] = '{6'd55, 32'h0,        1'b0, 7,  8'hFF, 8'h01, 8'h65, 8'h01, 1'b0, 8, 1'b1};
    vecs[4] = '{6'd41, 32'h4000_0000, 1'b0, 8, 8'hFF, 8'h00, 8'h77, 8'hFF, 1'b1, 8, 1'b1};
    vecs[5] = '{6'd41, 32'h4000_0000, 1'b1, 20, 8'hFF, 8'h00, 8'h77, 8'hFF, 1'b1, 8, 1'b1};
    vecs[6] = '{6'd17, 32'h0,        1'b0, 3,  8'h80, 8'h7F, 8'h55, 8'h7F, 1'b0, 4, 1'b1};
`else
    vecs[0] = '{6'd0,  32'h0,        1'b0, 2,  8'hFF, 8'h01, 8'h95, 8'h01, 1'b0, 3, 1'b1};
    vecs[1] = '{6'd8,  32'h1AA,      1'b0, 0,  8'hFF, 8'h01, 8'h87, 8'h01, 1'b0, 1, 1'b1};
    vecs[2] = '{6'd17, 32'h0,        1'b1, 1,  8'hFF, 8'h00, 8'h01, 8'h00, 1'b0, 2, 1'b0};
    vecs[3] = '{6'd55, 32'h0,        1'b0, 7,  8'hFF, 8'h01, 8'h01, 8'h01, 1'b0, 8, 1'b1};
    vecs[4] = '{6'd41, 32'h4000_0000, 1'b0, 8, 8'hFF, 8'h00, 8'h01, 8'hFF, 1'b1, 8, 1'b1};
    vecs[5] = '{6'd41, 32'h4000_0000, 1'b1, 20, 8'hFF, 8'h00, 8'h01, 8'hFF, 1'b1, 8, 1'b1};
    vecs[6] = '{6'd17, 32'h0,        1'b0, 3,  8'h80, 8'h7F, 8'h01, 8'h7F, 1'b0, 4, 1'b1};
`endif
    rst         = 1'b1;
    cmd_start   = 1'b0;
    cmd_index   = '0;
    cmd_arg     = '0;
    cmd_keep_cs = 1'b0;
    cs_release  = 1'b0;
    card_nff    = 0;
    card_fill   = 8'hFF;
    card_resp   = 8'h01;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_ctrl", {27'd0, spi_begin, spi_wide, cmd_busy, cmd_done, cmd_timeout}, 32'd0);
    chk("rst_mosi", data_mosi, 32'd0);
    chk("rst_r1", {24'd0, r1}, 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cs_n", {31'd0, cs_n}, 32'd1);

    for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

    // cmd_start and cs_release during POLL must be ignored.
    card_nff  = 5;
    card_fill = 8'hFF;
    card_resp = 8'h01;
    start_cmd(6'd0, 32'h0, 1'b0);
    for (int i = 0; i < 500 && polls < 2; i++) @(negedge clk);
    chk("reached_poll", (polls >= 2) ? 32'd1 : 32'd0, 32'd1);
    cmd_index   = 6'd17;
    cmd_arg     = 32'h1234_5678;
    cmd_keep_cs = 1'b1;
    cmd_start   = 1'b1;
    cs_release  = 1'b1;
    @(negedge clk);
    cmd_start   = 1'b0;
    cs_release  = 1'b0;
    chk("poll_cs_low", {31'd0, cs_n}, 32'd0);
    wait_done();
    chk("ign_r1", {24'd0, r1}, 32'h01);
    chk("ign_nbytes", log_n, 12);
    chk("ign_first", {24'd0, log_mem[0]}, 32'h40);
    @(negedge clk);
    chk("ign_cs_after", {31'd0, cs_n}, 32'd1);

    // Reset in the middle of the ARG transfer.
    card_nff = 0;
    start_cmd(6'd0, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 500 && !spi_wide; i++) @(negedge clk);
    chk("reached_arg", {31'd0, spi_wide}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("mid_rst_ctrl", {28'd0, spi_begin, spi_wide, cmd_busy, cmd_done}, 32'd0);
    chk("mid_rst_mosi", data_mosi, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, cmd_busy}, 32'd0);
    run_vec(vecs[0], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
